// File: rtl/hazard_if.sv
// Pipeline-to-hazard-unit signal bundle: register ids and control in, stall/flush/forward selects out.
// The pipeline drives through the master modport; hazard_unit uses the slave modport.
interface hazard_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] RsD;
    logic [REG_ADDR_W-1:0] RtD;
    logic                  BranchD;
    logic [REG_ADDR_W-1:0] RsE;
    logic [REG_ADDR_W-1:0] RtE;
    logic [REG_ADDR_W-1:0] WriteRegE;
    logic                  RegWriteE;
    logic                  MemtoRegE;
    logic [REG_ADDR_W-1:0] WriteRegM;
    logic                  RegWriteM;
    logic                  MemtoRegM;
    logic [REG_ADDR_W-1:0] WriteRegW;
    logic                  RegWriteW;
    logic                  MemReqM;
    logic                  MemReadyM;

    logic                  StallF;
    logic                  StallD;
    logic                  StallE;
    logic                  StallM;
    logic                  FlushE;
    logic                  FlushW;
    logic                  ForwardAD;
    logic                  ForwardBD;
    logic [1:0]            ForwardAE;
    logic [1:0]            ForwardBE;
    logic                  mem_busy;
    logic                  mem_timeout;
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output RsD, RtD, BranchD, RsE, RtE, WriteRegE, RegWriteE, MemtoRegE,
               WriteRegM, RegWriteM, MemtoRegM, WriteRegW, RegWriteW, MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushE, FlushW, ForwardAD, ForwardBD,
               ForwardAE, ForwardBE, mem_busy, mem_timeout, stall_cycles, flush_count
    );

    modport slave (
        input  RsD, RtD, BranchD, RsE, RtE, WriteRegE, RegWriteE, MemtoRegE,
               WriteRegM, RegWriteM, MemtoRegM, WriteRegW, RegWriteW, MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushE, FlushW, ForwardAD, ForwardBD,
               ForwardAE, ForwardBE, mem_busy, mem_timeout, stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_unit.sv
// Hazard detection, forwarding and variable-latency memory wait control for the five-stage pipeline.
// Define HAZARD_PERF_EN to build the stall_cycles / flush_count performance counters.
//
// state   | meaning
// IDLE    | no outstanding slow memory access
// WAIT    | data memory access in flight, pipeline frozen until MemReadyM
module hazard_unit #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic     clock,
    input  logic     reset,
    hazard_if.slave  hz
);
    localparam logic [REG_ADDR_W-1:0] ZERO_REG    = '0;
    localparam logic [CNT_W-1:0]      TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    mem_state_t       state;
    mem_state_t       state_next;
    logic             memstall;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    logic             timeout_flag;

    logic       lwstall;
    logic       branchstall;
    logic       hit_e;
    logic       hit_m;
    logic [1:0] fwd_ae;
    logic [1:0] fwd_be;
    logic       fwd_ad;
    logic       fwd_bd;

    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_e;
    logic flush_w;

    always_comb begin
        fwd_ae = 2'b00;
        if (hz.RsE != ZERO_REG && hz.RegWriteM && hz.WriteRegM == hz.RsE) begin
            fwd_ae = 2'b10;
        end else if (hz.RsE != ZERO_REG && hz.RegWriteW && hz.WriteRegW == hz.RsE) begin
            fwd_ae = 2'b01;
        end

        fwd_be = 2'b00;
        if (hz.RtE != ZERO_REG && hz.RegWriteM && hz.WriteRegM == hz.RtE) begin
            fwd_be = 2'b10;
        end else if (hz.RtE != ZERO_REG && hz.RegWriteW && hz.WriteRegW == hz.RtE) begin
            fwd_be = 2'b01;
        end

        fwd_ad = (hz.RsD != ZERO_REG) && hz.RegWriteM && (hz.WriteRegM == hz.RsD);
        fwd_bd = (hz.RtD != ZERO_REG) && hz.RegWriteM && (hz.WriteRegM == hz.RtD);
    end

    always_comb begin
        lwstall = hz.MemtoRegE && (hz.RtE != ZERO_REG) &&
                  ((hz.RtE == hz.RsD) || (hz.RtE == hz.RtD));
        hit_e = hz.RegWriteE &&
                (((hz.RsD != ZERO_REG) && (hz.RsD == hz.WriteRegE)) ||
                 ((hz.RtD != ZERO_REG) && (hz.RtD == hz.WriteRegE)));
        // Loads in M cannot be forwarded to the decode comparator, so they stall a branch.
        hit_m = hz.MemtoRegM &&
                (((hz.RsD != ZERO_REG) && (hz.RsD == hz.WriteRegM)) ||
                 ((hz.RtD != ZERO_REG) && (hz.RtD == hz.WriteRegM)));
        branchstall = hz.BranchD && (hit_e || hit_m);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        memstall   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hz.MemReqM && !hz.MemReadyM) begin
                    state_next = ST_WAIT;
                    memstall   = 1'b1;
                end
            end
            ST_WAIT: begin
                if (hz.MemReadyM) begin
                    state_next = ST_IDLE;
                end else begin
                    memstall = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        wait_cnt_next = wait_cnt;
        if (state == ST_IDLE && state_next == ST_WAIT) begin
            wait_cnt_next = '0;
        end else if (state == ST_WAIT && !hz.MemReadyM && wait_cnt != TIMEOUT_CNT) begin
            wait_cnt_next = wait_cnt + CNT_W'(1);
        end
    end

    // The watchdog only flags; the FSM keeps waiting for MemReadyM after a timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_next;
            if (state == ST_WAIT && wait_cnt_next == TIMEOUT_CNT) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (reset) begin
            flush_e = 1'b1;
            flush_w = 1'b1;
        end else if (memstall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (lwstall || branchstall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign hz.StallF      = stall_f;
    assign hz.StallD      = stall_d;
    assign hz.StallE      = stall_e;
    assign hz.StallM      = stall_m;
    assign hz.FlushE      = flush_e;
    assign hz.FlushW      = flush_w;
    assign hz.ForwardAE   = reset ? 2'b00 : fwd_ae;
    assign hz.ForwardBE   = reset ? 2'b00 : fwd_be;
    assign hz.ForwardAD   = !reset && fwd_ad;
    assign hz.ForwardBD   = !reset && fwd_bd;
    assign hz.mem_busy    = !reset && (state == ST_WAIT);
    assign hz.mem_timeout = timeout_flag;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             hazard_flush;

    assign hazard_flush = !reset && !memstall && (lwstall || branchstall);

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_f && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (hazard_flush && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign hz.stall_cycles = stall_cnt;
    assign hz.flush_count  = flush_cnt;
`else
    assign hz.stall_cycles = '0;
    assign hz.flush_count  = '0;
`endif

endmodule
